// File: rtl/refclk_pll_supervisor.sv
// Reference-clock PLL supervisor: sequences the PLL reset, debounces lock and
// qualifies downstream logic with clk_ready. Retries lock timeouts, then parks in FAULT.
module refclk_pll_supervisor #(
  parameter int RST_PULSE_CYCLES    = 50,
  parameter int LOCK_STABLE_CYCLES  = 5000,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int MAX_RETRIES         = 7
) (
  input  logic        refclk,
  input  logic        rst_n,
  input  logic        pll_locked,
  input  logic        force_relock,
  output logic        pll_rst,
  output logic        clk_ready,
  output logic        fault,
  output logic [15:0] lock_lost_count,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  localparam int PW = (RST_PULSE_CYCLES > 1) ? $clog2(RST_PULSE_CYCLES) : 1;
  localparam int SW = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
  localparam int TW = (LOCK_TIMEOUT_CYCLES > 1) ? $clog2(LOCK_TIMEOUT_CYCLES) : 1;
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [PW-1:0] PULSE_LAST  = PW'(RST_PULSE_CYCLES - 1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST    = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRIES);

  logic [1:0]    sync_q;
  logic          locked_s;
  state_t        state_q, state_d;
  logic [PW-1:0] pulse_q, pulse_d;
  logic [SW-1:0] stab_q, stab_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          tmo_hit, stab_hit, lost_inc;

  // pll_locked is asynchronous to refclk; only the synchronized copy is used.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], pll_locked};
  end
  assign locked_s = sync_q[1];

  assign tmo_hit  = (tmo_q == TMO_LAST);
  assign stab_hit = (stab_q == STABLE_LAST);
  assign lost_inc = (state_q == RUN) && !locked_s && (lock_lost_count != 16'hFFFF);

  always_comb begin
    state_d = state_q;
    pulse_d = pulse_q;
    stab_d  = stab_q;
    tmo_d   = tmo_q;
    retry_d = retry_q;
    case (state_q)
      RESET_PLL: begin
        tmo_d  = '0;
        stab_d = '0;
        if (pulse_q == PULSE_LAST) begin
          state_d = WAIT_LOCK;
          pulse_d = '0;
        end else begin
          pulse_d = pulse_q + 1'b1;
        end
      end
      WAIT_LOCK, STABLE: begin
        tmo_d = tmo_q + 1'b1;
        // Lock qualified on the final budget cycle still counts as success.
        if (state_q == STABLE && locked_s && stab_hit) begin
          state_d = RUN;
          retry_d = '0;
          tmo_d   = '0;
          stab_d  = '0;
        end else if (tmo_hit) begin
          tmo_d  = '0;
          stab_d = '0;
          if (retry_q < RETRY_MAX) begin
            state_d = RESET_PLL;
            pulse_d = '0;
            retry_d = retry_q + 1'b1;
          end else begin
            state_d = FAULT;
          end
        end else if (state_q == WAIT_LOCK) begin
          if (locked_s) begin
            state_d = STABLE;
            stab_d  = '0;
          end
        end else if (!locked_s) begin
          // Timeout keeps running so a bouncing lock still expires.
          state_d = WAIT_LOCK;
          stab_d  = '0;
        end else begin
          stab_d = stab_q + 1'b1;
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_d = RESET_PLL;
          pulse_d = '0;
          tmo_d   = '0;
          stab_d  = '0;
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = RESET_PLL;
        pulse_d = '0;
        tmo_d   = '0;
        stab_d  = '0;
      end
    endcase
    if (force_relock) begin
      state_d = RESET_PLL;
      pulse_d = '0;
      stab_d  = '0;
      tmo_d   = '0;
      retry_d = '0;
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= RESET_PLL;
      pulse_q         <= '0;
      stab_q          <= '0;
      tmo_q           <= '0;
      retry_q         <= '0;
      lock_lost_count <= '0;
      pll_rst         <= 1'b1;
      clk_ready       <= 1'b0;
      fault           <= 1'b0;
    end else begin
      state_q   <= state_d;
      pulse_q   <= pulse_d;
      stab_q    <= stab_d;
      tmo_q     <= tmo_d;
      retry_q   <= retry_d;
      pll_rst   <= (state_d == RESET_PLL) || (state_d == FAULT);
      clk_ready <= (state_d == RUN);
      fault     <= (state_d == FAULT);
      if (lost_inc) lock_lost_count <= lock_lost_count + 16'd1;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_refclk_pll_supervisor.sv
// Directed bench for refclk_pll_supervisor with small parameters
// (pulse 4, stable 8, timeout 32, retries 2).
module tb_refclk_pll_supervisor;

  logic        refclk;
  logic        rst_n;
  logic        pll_locked;
  logic        force_relock;
  logic        pll_rst;
  logic        clk_ready;
  logic        fault;
  logic [15:0] lock_lost_count;
  logic [2:0]  state;

  int checks   = 0;
  int failures = 0;

  refclk_pll_supervisor #(
    .RST_PULSE_CYCLES    (4),
    .LOCK_STABLE_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES (32),
    .MAX_RETRIES         (2)
  ) dut (
    .refclk          (refclk),
    .rst_n           (rst_n),
    .pll_locked      (pll_locked),
    .force_relock    (force_relock),
    .pll_rst         (pll_rst),
    .clk_ready       (clk_ready),
    .fault           (fault),
    .lock_lost_count (lock_lost_count),
    .state           (state)
  );

  // Clock/reset
  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  typedef struct {
    logic        locked;
    logic        force_r;
    int          cycles;
    logic        exp_pll_rst;
    logic        exp_clk_ready;
    logic        exp_fault;
    logic [2:0]  exp_state;
  } vec_t;

  vec_t vecs[20];

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drop lock while in RUN; optionally assert force_relock on the edge that sees the loss.
  task automatic lose_lock(input bit with_force, input int exp_cnt);
    pll_locked = 1'b0;
    tick();
    tick();
    check("loss_ready_edge2", 32'(clk_ready), 32'd1);
    if (with_force) force_relock = 1'b1;
    tick();
    force_relock = 1'b0;
    check("loss_ready_edge3", 32'(clk_ready), 32'd0);
    check("loss_pll_rst_edge3", 32'(pll_rst), 32'd1);
    check("loss_count", 32'(lock_lost_count), 32'(exp_cnt));
    check("loss_state", 32'(state), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("loss_pulse_hi", 32'(pll_rst), 32'd1);
    end
    tick();
    check("loss_pulse_end", 32'(pll_rst), 32'd0);
    check("loss_wait_state", 32'(state), 32'd1);
  endtask

  task automatic relock();
    pll_locked = 1'b1;
    repeat (10) tick();
    check("relock_not_yet", 32'(clk_ready), 32'd0);
    tick();
    check("relock_ready", 32'(clk_ready), 32'd1);
    check("relock_state", 32'(state), 32'd3);
  endtask

  initial begin
    // Retry exhaustion, FAULT hold and recovery: each row holds inputs for N edges then checks.
    vecs[0]  = '{1'b0, 1'b0,  3, 1'b1, 1'b0, 1'b0, 3'd0};
    vecs[1]  = '{1'b0, 1'b0,  1, 1'b0, 1'b0, 1'b0, 3'd1};
    vecs[2]  = '{1'b0, 1'b0, 31, 1'b0, 1'b0, 1'b0, 3'd1};
    vecs[3]  = '{1'b0, 1'b0,  1, 1'b1, 1'b0, 1'b0, 3'd0};
    vecs[4]  = '{1'b0, 1'b0,  3, 1'b1, 1'b0, 1'b0, 3'd0};
    vecs[5]  = '{1'b0, 1'b0,  1, 1'b0, 1'b0, 1'b0, 3'd1};
    vecs[6]  = '{1'b0, 1'b0, 31, 1'b0, 1'b0, 1'b0, 3'd1};
    vecs[7]  = '{1'b0, 1'b0,  1, 1'b1, 1'b0, 1'b0, 3'd0};
    vecs[8]  = '{1'b0, 1'b0,  3, 1'b1, 1'b0, 1'b0, 3'd0};
    vecs[9]  = '{1'b0, 1'b0,  1, 1'b0, 1'b0, 1'b0, 3'd1};
    vecs[10] = '{1'b0, 1'b0, 31, 1'b0, 1'b0, 1'b0, 3'd1};
    vecs[11] = '{1'b0, 1'b0,  1, 1'b1, 1'b0, 1'b1, 3'd4};
    vecs[12] = '{1'b0, 1'b0, 20, 1'b1, 1'b0, 1'b1, 3'd4};
    vecs[13] = '{1'b0, 1'b1,  1, 1'b1, 1'b0, 1'b0, 3'd0};
    vecs[14] = '{1'b0, 1'b0,  3, 1'b1, 1'b0, 1'b0, 3'd0};
    vecs[15] = '{1'b1, 1'b0,  1, 1'b0, 1'b0, 1'b0, 3'd1};
    vecs[16] = '{1'b1, 1'b0,  1, 1'b0, 1'b0, 1'b0, 3'd1};
    vecs[17] = '{1'b1, 1'b0,  1, 1'b0, 1'b0, 1'b0, 3'd2};
    vecs[18] = '{1'b1, 1'b0,  7, 1'b0, 1'b0, 1'b0, 3'd2};
    vecs[19] = '{1'b1, 1'b0,  1, 1'b0, 1'b1, 1'b0, 3'd3};

    rst_n        = 1'b0;
    pll_locked   = 1'b0;
    force_relock = 1'b0;
    repeat (3) tick();
    check("rst_state", 32'(state), 32'd0);
    check("rst_pll_rst", 32'(pll_rst), 32'd1);
    check("rst_clk_ready", 32'(clk_ready), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_count", 32'(lock_lost_count), 32'd0);

    // Power-up: 4-cycle pulse, lock raised 2 cycles after it ends.
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("pwr_pulse_hi", 32'(pll_rst), 32'd1);
    end
    tick();
    check("pwr_pulse_end", 32'(pll_rst), 32'd0);
    check("pwr_wait_state", 32'(state), 32'd1);
    tick();
    tick();
    pll_locked = 1'b1;
    tick();
    tick();
    check("pwr_sync_wait", 32'(state), 32'd1);
    tick();
    check("pwr_stable", 32'(state), 32'd2);
    repeat (7) tick();
    check("pwr_not_ready", 32'(clk_ready), 32'd0);
    tick();
    check("pwr_ready", 32'(clk_ready), 32'd1);
    check("pwr_run_state", 32'(state), 32'd3);
    check("pwr_pll_rst_low", 32'(pll_rst), 32'd0);

    // Three lock losses in RUN.
    for (int k = 1; k <= 3; k++) begin
      lose_lock(1'b0, k);
      relock();
    end
    check("three_losses", 32'(lock_lost_count), 32'd3);

    // Fourth loss, then a one-cycle lock bounce at stable count 5.
    lose_lock(1'b0, 4);
    pll_locked = 1'b1;
    repeat (8) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    tick();
    check("bounce_in_stable", 32'(state), 32'd2);
    tick();
    check("bounce_back_wait", 32'(state), 32'd1);
    tick();
    check("bounce_restable", 32'(state), 32'd2);
    repeat (7) tick();
    check("bounce_not_ready", 32'(clk_ready), 32'd0);
    tick();
    check("bounce_ready", 32'(clk_ready), 32'd1);
    check("bounce_run", 32'(state), 32'd3);

    // force_relock coincident with a RUN lock loss still counts the loss.
    lose_lock(1'b1, 5);
    relock();
    check("count_before_async", 32'(lock_lost_count), 32'd5);

    // Asynchronous reset mid-RUN, observed between clock edges.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clk_ready", 32'(clk_ready), 32'd0);
    check("async_pll_rst", 32'(pll_rst), 32'd1);
    check("async_count", 32'(lock_lost_count), 32'd0);
    check("async_state", 32'(state), 32'd0);
    check("async_fault", 32'(fault), 32'd0);
    pll_locked = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      pll_locked   = vecs[i].locked;
      force_relock = vecs[i].force_r;
      repeat (vecs[i].cycles) tick();
      force_relock = 1'b0;
      check($sformatf("row%0d_pll_rst", i), 32'(pll_rst), 32'(vecs[i].exp_pll_rst));
      check($sformatf("row%0d_clk_ready", i), 32'(clk_ready), 32'(vecs[i].exp_clk_ready));
      check($sformatf("row%0d_fault", i), 32'(fault), 32'(vecs[i].exp_fault));
      check($sformatf("row%0d_state", i), 32'(state), 32'(vecs[i].exp_state));
      check($sformatf("row%0d_count", i), 32'(lock_lost_count), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
